wino_tile_scheduler: RTL and testbench

WINO_TILE_SCHEDULER -- requirements
Module: wino_tile_scheduler

---
 rtl/wino_tile_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_wino_tile_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_tile_scheduler.sv
// ---------------------------------------------------------------------------
// wino_tile_scheduler
//   Walks a frame of 4x3 input tiles in raster order. For each tile it reads
//   three consecutive buffer rows, applies the row/column Winograd input
//   transform and presents the 12 transformed elements on a valid/ready port.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a frame (sampled only while idle)
//   cfg_base          word address of the first tile row
//   cfg_stride        words between vertically adjacent rows
//   cfg_tiles_x/_y    tiles per row / number of tile rows
//   rd_en, rd_addr    buffer read strobe and address
//   rd_data           row word returned one cycle after rd_en (4 elements)
//   out_valid/ready   transformed tile handshake
//   out_data          12 transformed elements, element k at [k*DW +: DW]
//   out_tile_x/_y     coordinates of the presented tile
//   busy              high whenever the scheduler is not idle
//   done              one-cycle pulse when the frame completes
// ---------------------------------------------------------------------------
module wino_tile_scheduler #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_stride,
  input  logic [7:0]                cfg_tiles_x,
  input  logic [7:0]                cfg_tiles_y,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [4*DATA_WIDTH-1:0]   rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [12*DATA_WIDTH-1:0]  out_data,
  output logic [7:0]                out_tile_x,
  output logic [7:0]                out_tile_y,
  output logic                      busy,
  output logic                      done
);

  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] row_addr;   // address of column 0 in the current tile row
  logic [7:0]            tiles_x_q;
  logic [7:0]            tiles_y_q;
  logic [7:0]            tx;
  logic [7:0]            ty;
  logic [4*DW-1:0]       row0_p1;
  logic [4*DW-1:0]       row1_p1;
  logic [12*DW-1:0]      tile_p2;
  logic                  last_col;
  logic                  last_tile;

  // Two's complement wrap: results are truncated to DW bits, never saturated.
  function automatic logic signed [DW-1:0] add_w(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return a + b;
  endfunction

  function automatic logic signed [DW-1:0] sub_w(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return a - b;
  endfunction

  function automatic logic [12*DW-1:0] wino_xform(input logic [4*DW-1:0] r0,
                                                  input logic [4*DW-1:0] r1,
                                                  input logic [4*DW-1:0] r2);
    logic signed [DW-1:0] t [3][4];
    logic [12*DW-1:0]     o;
    for (int j = 0; j < 4; j++) begin
      t[0][j] = add_w(r0[j*DW +: DW], r1[j*DW +: DW]);
      t[1][j] = sub_w(r1[j*DW +: DW], r0[j*DW +: DW]);
      t[2][j] = sub_w(r2[j*DW +: DW], r0[j*DW +: DW]);
    end
    for (int i = 0; i < 3; i++) begin
      o[(4*i+0)*DW +: DW] = sub_w(t[i][0], t[i][2]);
      o[(4*i+1)*DW +: DW] = add_w(t[i][1], t[i][2]);
      o[(4*i+2)*DW +: DW] = sub_w(t[i][2], t[i][1]);
      o[(4*i+3)*DW +: DW] = sub_w(t[i][1], t[i][3]);
    end
    return o;
  endfunction

  // ---- stage p2: row 2 arrives on rd_data during CAP and is used directly
  always_comb begin
    tile_p2 = wino_xform(row0_p1, row1_p1, rd_data);
  end

  assign last_col  = (tx == tiles_x_q - 8'd1);
  assign last_tile = last_col && (ty == tiles_y_q - 8'd1);

  // ---- stage p1: row capture registers (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == RD1) row0_p1 <= rd_data;
    if (state == RD2) row1_p1 <= rd_data;
  end

  // ---- control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stride_q   <= '0;
      row_addr   <= '0;
      tiles_x_q  <= '0;
      tiles_y_q  <= '0;
      tx         <= '0;
      ty         <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tile_x <= '0;
      out_tile_y <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stride_q  <= cfg_stride;
            tiles_x_q <= cfg_tiles_x;
            tiles_y_q <= cfg_tiles_y;
            row_addr  <= cfg_base;
            tx        <= '0;
            ty        <= '0;
            busy      <= 1'b1;
            if (cfg_tiles_x == 8'd0 || cfg_tiles_y == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RD0;
              rd_en   <= 1'b1;
              rd_addr <= cfg_base;
            end
          end
        end
        RD0: begin
          state   <= RD1;
          rd_en   <= 1'b1;
          rd_addr <= rd_addr + stride_q;
        end
        RD1: begin
          state   <= RD2;
          rd_en   <= 1'b1;
          rd_addr <= rd_addr + stride_q;
        end
        RD2: begin
          state <= CAP;
        end
        CAP: begin
          state      <= OUT;
          out_valid  <= 1'b1;
          out_data   <= tile_p2;
          out_tile_x <= tx;
          out_tile_y <= ty;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_tile) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD0;
              rd_en <= 1'b1;
              if (last_col) begin
                tx       <= '0;
                ty       <= ty + 8'd1;
                row_addr <= row_addr + stride_q;
                rd_addr  <= row_addr + stride_q;
              end else begin
                tx      <= tx + 8'd1;
                rd_addr <= row_addr + ADDR_WIDTH'(tx + 8'd1);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wino_tile_scheduler.sv
module tb_wino_tile_scheduler;

  localparam int DW = 18;
  localparam int AW = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [AW-1:0]     cfg_base;
  logic [AW-1:0]     cfg_stride;
  logic [7:0]        cfg_tiles_x;
  logic [7:0]        cfg_tiles_y;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [4*DW-1:0]   rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [12*DW-1:0]  out_data;
  logic [7:0]        out_tile_x;
  logic [7:0]        out_tile_y;
  logic              busy;
  logic              done;

  wino_tile_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_tiles_x(cfg_tiles_x),
    .cfg_tiles_y(cfg_tiles_y),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tile_x (out_tile_x),
    .out_tile_y (out_tile_y),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row buffer model: one-cycle read latency.
  logic [4*DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [2:0][3:0][DW-1:0] r;
    logic [11:0][DW-1:0]     e;
  } vec_t;

  vec_t vecs [6];

  int n_cmp;
  int n_bad;

  function automatic logic [3:0][DW-1:0] row4(input int a0, a1, a2, a3);
    logic [3:0][DW-1:0] r;
    r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
    return r;
  endfunction

  function automatic logic [11:0][DW-1:0] exp12(input int k0, k1, k2, k3, k4, k5,
                                                input int k6, k7, k8, k9, k10, k11);
    logic [11:0][DW-1:0] e;
    e[0] = DW'(k0); e[1] = DW'(k1); e[2]  = DW'(k2);  e[3]  = DW'(k3);
    e[4] = DW'(k4); e[5] = DW'(k5); e[6]  = DW'(k6);  e[7]  = DW'(k7);
    e[8] = DW'(k8); e[9] = DW'(k9); e[10] = DW'(k10); e[11] = DW'(k11);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 1x1 frame from vecs[v]; out_ready held high.
  task automatic run_single(input int v);
    logic [11:0][DW-1:0] got;
    int vcyc;
    int dcyc;
    int dn;
    vcyc = -1; dcyc = -1; dn = 0; got = '0;
    mem[0] = vecs[v].r[0];
    mem[1] = vecs[v].r[1];
    mem[2] = vecs[v].r[2];
    cfg_base = '0; cfg_stride = 10'd1; cfg_tiles_x = 8'd1; cfg_tiles_y = 8'd1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid && vcyc < 0) begin
        vcyc = c;
        got  = out_data;
      end
      if (done) begin
        dn++;
        dcyc = c;
      end
      step();
    end
    chk($sformatf("v%0d_valid_cycle", v), 64'(vcyc), 64'd5);
    for (int k = 0; k < 12; k++)
      chk($sformatf("v%0d_out%0d", v, k), 64'(got[k]), 64'(vecs[v].e[k]));
    chk($sformatf("v%0d_done_cycle", v), 64'(dcyc), 64'd6);
    chk($sformatf("v%0d_done_count", v), 64'(dn), 64'd1);
  endtask

  int          addrs [$];
  int          xs [$];
  int          ys [$];
  int          vcycs [$];
  int          exp_addr [12];
  int          hs;
  int          dn;
  int          dcyc;
  int          bad_v;
  int          bad_d;
  int          bad_r;
  logic [12*DW-1:0] ref_data;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_tiles_x = '0; cfg_tiles_y = '0;
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {DW'(i + 3), DW'(i * 7), DW'(i + 100), DW'(i)};

    vecs[0].r = {row4(9, 10, 11, 12), row4(5, 6, 7, 8), row4(1, 2, 3, 4)};
    vecs[0].e = exp12('h3FFFC, 18, 2, 'h3FFFC, 0, 8, 0, 0, 0, 16, 0, 0);
    vecs[1].r = {row4('h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF),
                 row4('h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF),
                 row4('h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF)};
    vecs[1].e = exp12(0, 'h3FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].r = {row4(0, 0, 0, 0), row4(1, 0, 0, 0), row4(0, 0, 0, 0)};
    vecs[2].e = exp12(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].r = {row4(0, 0, 0, 5), row4(0, 0, 0, 0), row4(0, 0, 0, 0)};
    vecs[3].e = exp12(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -5);
    vecs[4].r = {row4(0, 0, 0, 0), row4(0, 0, 0, 0), row4(0, 1, 0, 0)};
    vecs[4].e = exp12(0, 1, -1, 1, 0, -1, 1, -1, 0, -1, 1, -1);
    vecs[5].r = {row4(0, 0, 0, 0), row4(0, 0, 0, 0), row4(0, 0, 'h20000, 0)};
    vecs[5].e = exp12('h20000, 'h20000, 'h20000, 0, 'h20000, 'h20000, 'h20000, 0,
                      'h20000, 'h20000, 'h20000, 0);

    exp_addr = '{'h10, 'h18, 'h20, 'h11, 'h19, 'h21, 'h18, 'h20, 'h28, 'h19, 'h21, 'h29};

    step(); step();
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    step();

    // Table-driven single-tile transform vectors.
    for (int v = 0; v < 6; v++) run_single(v);

    // 2x2 addressing, raster order and tile period.
    for (int i = 0; i < 64; i++) mem[i] = {DW'(i + 3), DW'(i * 7), DW'(i + 100), DW'(i)};
    cfg_base = 10'h10; cfg_stride = 10'd8; cfg_tiles_x = 8'd2; cfg_tiles_y = 8'd2;
    out_ready = 1'b1;
    hs = 0; dn = 0; dcyc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_base = 10'h3FF; cfg_stride = 10'd1;
    for (int c = 1; c <= 30; c++) begin
      if (rd_en) addrs.push_back(int'(rd_addr));
      if (out_valid && out_ready) begin
        hs++;
        xs.push_back(int'(out_tile_x));
        ys.push_back(int'(out_tile_y));
        vcycs.push_back(c);
      end
      if (done) begin dn++; dcyc = c; end
      step();
    end
    chk("addr_count", 64'(addrs.size()), 64'd12);
    for (int i = 0; i < 12 && i < addrs.size(); i++)
      chk($sformatf("addr%0d", i), 64'(addrs[i]), 64'(exp_addr[i]));
    chk("handshakes", 64'(hs), 64'd4);
    for (int i = 0; i < 4 && i < xs.size(); i++) begin
      chk($sformatf("tile%0d_x", i), 64'(xs[i]), 64'(i % 2));
      chk($sformatf("tile%0d_y", i), 64'(ys[i]), 64'(i / 2));
      chk($sformatf("tile%0d_cycle", i), 64'(vcycs[i]), 64'(5 + 5 * i));
    end
    chk("grid_done_count", 64'(dn), 64'd1);
    chk("grid_done_cycle", 64'(dcyc), 64'd21);

    // Reset in RD2: out_data / tile coords still hold the last 2x2 tile.
    cfg_base = '0; cfg_stride = 10'd1; cfg_tiles_x = 8'd1; cfg_tiles_y = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_rd2_rd_en", 64'(rd_en), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
    chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data_zero", 64'(out_data == '0), 64'd1);
    chk("mid_rst_tile_x", 64'(out_tile_x), 64'd0);
    chk("mid_rst_tile_y", 64'(out_tile_y), 64'd0);
    bad_r = 0; dn = 0; bad_v = 0;
    for (int c = 0; c < 8; c++) begin
      if (rd_en) bad_r++;
      if (done) dn++;
      if (out_valid) bad_v++;
      step();
    end
    chk("post_rst_reads", 64'(bad_r), 64'd0);
    chk("post_rst_done", 64'(dn), 64'd0);
    chk("post_rst_valid", 64'(bad_v), 64'd0);
    run_single(0);

    // Backpressure on tile 0 of a 2x1 frame.
    mem['h40] = vecs[0].r[0];
    mem['h41] = vecs[0].r[1];
    mem['h42] = vecs[0].r[2];
    cfg_base = 10'h40; cfg_stride = 10'd1; cfg_tiles_x = 8'd2; cfg_tiles_y = 8'd1;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    chk("bp_valid_c5", 64'(out_valid), 64'd1);
    chk("bp_data_c5", 64'(out_data == vecs[0].e), 64'd1);
    ref_data = out_data;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int c = 5; c < 15; c++) begin
      if (!out_valid) bad_v++;
      if (out_data !== ref_data) bad_d++;
      if (rd_en) bad_r++;
      step();
    end
    chk("bp_valid_held", 64'(bad_v), 64'd0);
    chk("bp_data_stable", 64'(bad_d), 64'd0);
    chk("bp_no_reads", 64'(bad_r), 64'd0);
    chk("bp_valid_c15", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_next_rd_en", 64'(rd_en), 64'd1);
    chk("bp_next_rd_addr", 64'(rd_addr), 64'h41);
    chk("bp_valid_dropped", 64'(out_valid), 64'd0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      step();
    end
    chk("bp_done_count", 64'(dn), 64'd1);

    // Zero tile count; start held through DONE must be ignored.
    cfg_tiles_x = 8'd0; cfg_tiles_y = 8'd3;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    chk("zero_done_c1", 64'(done), 64'd1);
    chk("zero_busy_c1", 64'(busy), 64'd1);
    chk("zero_rd_en_c1", 64'(rd_en), 64'd0);
    step();
    start = 1'b0;
    chk("zero_done_c2", 64'(done), 64'd0);
    chk("zero_busy_c2", 64'(busy), 64'd0);
    bad_r = 0; bad_v = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_en) bad_r++;
      if (out_valid) bad_v++;
      step();
    end
    chk("zero_no_reads", 64'(bad_r), 64'd0);
    chk("zero_no_valid", 64'(bad_v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
